// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Iterative shift-and-add-3 (double dabble) binary-to-BCD converter. One input
// bit is consumed per clock. The result is the value modulo 10^DIGITS. Any
// weight above the top digit is folded into a sticky overflow flag.
//
// Ports
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous, active-high reset
//   start  in   1          conversion request, only looked at in IDLE
//   bin    in   WIDTH      binary value, captured on the accepting edge
//   busy   out  1          high whenever the FSM is not in IDLE
//   done   out  1          one-cycle pulse; bcd/ovf hold the new result
//   bcd    out  4*DIGITS   packed BCD, [3:0]=units, [7:4]=tens, ...
//   ovf    out  1          value >= 10^DIGITS (upper digits were dropped)
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; bcd/ovf hold the last result
//   S_SHIFT | WIDTH edges of add-3 followed by shift-left
//   S_DONE  | single cycle with done=1, then back to IDLE
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             sticky_q,  sticky_d;
    logic [BW-1:0]    bcd_q,     bcd_d;
    logic             ovf_q,     ovf_d;

    // Per-nibble add-3 correction. Nibbles never exceed 9 here, so the
    // 4-bit sum cannot wrap and no carry between digits is needed.
    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_nxt;
    logic [WIDTH-1:0] shreg_nxt;
    logic             sticky_nxt;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
    end

    // {sticky, adj, shreg} shifted left by one; the bit falling off the top
    // digit would belong to a digit we do not keep, so it only marks overflow.
    always_comb begin
        scratch_nxt = {adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_nxt   = {shreg_q[WIDTH-2:0], 1'b0};
        sticky_nxt  = sticky_q | adj[BW-1];
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    sticky_d  = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = shreg_nxt;
                scratch_d = scratch_nxt;
                sticky_d  = sticky_nxt;
                cnt_d     = cnt_q - CW'(1);
                // Publish only on the last bit so no partial value is seen.
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scratch_nxt;
                    ovf_d   = sticky_nxt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] bin;
    logic       busy;
    logic       done;
    logic [7:0] bcd;
    logic       ovf;

    logic       start7;
    logic [6:0] bin7;
    logic       busy7;
    logic       done7;
    logic [7:0] bcd7;
    logic       ovf7;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2)) dut7 (
        .clk   (clk),
        .rst   (rst),
        .start (start7),
        .bin   (bin7),
        .busy  (busy7),
        .done  (done7),
        .bcd   (bcd7),
        .ovf   (ovf7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a conversion on the WIDTH=6 instance from IDLE, waits (bounded)
    // for done, then steps one more edge so the FSM is back in IDLE.
    task automatic run_conv(input logic [5:0] v, output logic [7:0] b,
                            output logic o, output int edges,
                            output logic done_after, output logic busy_after);
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        b = bcd;
        o = ovf;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0; start7 = 1'b0; bin7 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (bcd !== 8'h00) begin bad++; $display("FAIL reset_bcd: got %h want 00", bcd); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        total++; if (busy7 !== 1'b0 || bcd7 !== 8'h00) begin bad++; $display("FAIL reset_w7: got busy=%b bcd=%h want 0/00", busy7, bcd7); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [5:0] vin [4] = '{6'd0, 6'd49, 6'd36, 6'd63};
        logic [7:0] vexp[4] = '{8'h00, 8'h49, 8'h36, 8'h63};
        logic [7:0] b;
        logic o, da, ba;
        int e;
        for (int i = 0; i < 4; i++) begin
            run_conv(vin[i], b, o, e, da, ba);
            total++; if (e !== 6) begin bad++; $display("FAIL basic_latency bin=%0d: got %0d edges want 6", vin[i], e); end
            total++; if (b !== vexp[i]) begin bad++; $display("FAIL basic_bcd bin=%0d: got %h want %h", vin[i], b, vexp[i]); end
            total++; if (o !== 1'b0) begin bad++; $display("FAIL basic_ovf bin=%0d: got %b want 0", vin[i], o); end
            total++; if (da !== 1'b0 || ba !== 1'b0) begin bad++; $display("FAIL basic_idle bin=%0d: got done=%b busy=%b want 0/0", vin[i], da, ba); end
        end
    endtask

    task automatic test_async_rst();
        // bcd holds 63 from the previous test; reset lands between edges.
        #2;
        rst = 1'b1;
        #1;
        total++; if (bcd !== 8'h00 || ovf !== 1'b0) begin bad++; $display("FAIL async_rst_out: got bcd=%h ovf=%b want 00/0", bcd, ovf); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL async_rst_ctl: got busy=%b done=%b want 0/0", busy, done); end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int e = 0;
        bin = 6'd12; start = 1'b1;
        @(posedge clk); #1;
        bin = 6'd5;                       // start stays high through SHIFT/DONE
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 6) begin
                total++; if (done !== 1'b1 || bcd !== 8'h12) begin bad++; $display("FAIL ignore_result: got done=%b bcd=%h want 1/12", done, bcd); end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_single_done: got %0d want 1", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_accept_in_done: got busy=%b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1 || bcd !== 8'h12) begin bad++; $display("FAIL ignore_accept_after_done: got busy=%b bcd=%h want 1/12", busy, bcd); end
        while (!done && e < 20) begin
            @(posedge clk); #1;
            e++;
            if (!done && bcd !== 8'h12) begin
                total++; bad++; $display("FAIL ignore_hold: got %h want 12", bcd);
            end
        end
        total++; if (done !== 1'b1 || bcd !== 8'h05) begin bad++; $display("FAIL ignore_second: got done=%b bcd=%h want 1/05", done, bcd); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        logic [7:0] b;
        logic o, da, ba;
        int e;
        bin = 6'd42; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);        // three bits done, cnt now 3
        #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl: got busy=%b done=%b want 0/0", busy, done); end
        total++; if (bcd !== 8'h00 || ovf !== 1'b0) begin bad++; $display("FAIL rst_mid_out: got bcd=%h ovf=%b want 00/0", bcd, ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", ndone); end
        run_conv(6'd42, b, o, e, da, ba);
        total++; if (b !== 8'h42 || o !== 1'b0 || e !== 6) begin bad++; $display("FAIL rst_mid_restart: got bcd=%h ovf=%b edges=%0d want 42/0/6", b, o, e); end
    endtask

    task automatic test_width7();
        logic [6:0] vin [3] = '{7'd100, 7'd99, 7'd127};
        logic [7:0] vexp[3] = '{8'h00, 8'h99, 8'h27};
        logic       oexp[3] = '{1'b1, 1'b0, 1'b1};
        int e;
        for (int i = 0; i < 3; i++) begin
            bin7 = vin[i]; start7 = 1'b1;
            @(posedge clk); #1;
            start7 = 1'b0;
            e = 0;
            while (!done7 && e < 20) begin
                @(posedge clk); #1;
                e++;
            end
            total++; if (e !== 7) begin bad++; $display("FAIL w7_latency bin=%0d: got %0d want 7", vin[i], e); end
            total++; if (bcd7 !== vexp[i]) begin bad++; $display("FAIL w7_bcd bin=%0d: got %h want %h", vin[i], bcd7, vexp[i]); end
            total++; if (ovf7 !== oexp[i]) begin bad++; $display("FAIL w7_ovf bin=%0d: got %b want %b", vin[i], ovf7, oexp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, exp_b;
        logic o, da, ba;
        int e;
        for (int v = 0; v < 64; v++) begin
            exp_b = 8'((v / 10) * 16 + (v % 10));
            run_conv(6'(v), b, o, e, da, ba);
            total++; if (b !== exp_b || o !== 1'b0) begin bad++; $display("FAIL b2b_value bin=%0d: got bcd=%h ovf=%b want %h/0", v, b, o, exp_b); end
            total++; if (e !== 6 || da !== 1'b0) begin bad++; $display("FAIL b2b_done_width bin=%0d: got edges=%0d done_after=%b want 6/0", v, e, da); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_rst();
        test_ignore_start();
        test_reset_mid();
        test_width7();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
